pic_inta_sequencer: RTL
=======================

# pic_inta_sequencer

Clocked interrupt-acknowledge controller for the PIC. It resolves fixed-priority requests against the in-service register and raises INT. It then runs the two-pulse INTA protocol, which sets the ISR, drives the CAS lines (master) or matches them against its own ID (slave), and enables the vector onto the data bus. It sits between the IRR/IMR logic and the cascade buffer and data bus buffer, and it sequences both of them.

## Interface
- `NUM_IR`, 8, number of interrupt lines (fixed priority, IR0 highest)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low
- `ir_req`  in  8  masked, level interrupt requests from IRR/IMR
- `sngl`  in  1  1 = single PIC, 0 = cascade
- `sp_en`  in  1  cascade role: 1 = master, 0 = slave
- `slave_map`  in  8  master ICW3: bit n = slave on IRn
- `slave_id`  in  3  slave ICW3: own cascade ID
- `vector_base`  in  5  ICW2 T7–T3
- `inta_n`  in  1  INTA, already synchronised to `clk`, active low
- `eoi`  in  1  one-cycle non-specific EOI strobe
- `cas_in`  in  3  CAS lines as seen on the bus
- `int_out`  out  1  INT to CPU or to master
- `cas_out`  out  3  cascade address to drive
- `cas_oe`  out  1  CAS driver enable
- `data_out`  out  8  interrupt vector
- `data_oe`  out  1  data bus driver enable
- `isr`  out  8  in-service register

## Operation
- Edge detect on `inta_n`: a falling edge is `inta_q & ~inta_n`. A rising edge is the inverse.
- `sngl`, `sp_en`, `slave_map`, `slave_id` and `vector_base` are latched on IDLE→REQ and held until the sequence returns to IDLE.
- FSM states and transitions:
  - **IDLE**
    - Winner = lowest-index `ir_req` bit whose priority is above the highest set `isr` bit (fully nested).
    - If a winner exists: latch `irq_id`, go to REQ.
  - **REQ**
    - `int_out`=1.
    - On first INTA fall, `int_out`=0 and the winner is re-resolved:
      - No request left → spurious: `irq_id`=7, no ISR set.
      - Otherwise a new winner may replace the old one.
    - Master or single: set `isr[irq_id]` (unless spurious), go to ACK1.
    - Slave: go to ACK1 without setting ISR.
  - **ACK1**
    - Master cascade with `slave_map[irq_id]`=1: `cas_oe`=1, `cas_out`=`irq_id`.
    - Waits for second INTA fall, then goes to ACK2.
  - **ACK2**
    - Entry decision:
      - Slave: `cas_in`==`slave_id` → set `isr[irq_id]`, respond. Mismatch → no response, go to IDLE.
      - Master with a slave on `irq_id`: never drives data.
      - Otherwise: respond.
    - Responding: `data_oe`=1, `data_out`={`vector_base`,`irq_id`} while `inta_n` is low.
    - Second INTA rise → IDLE; `data_oe`, `cas_oe` drop.
- EOI:
  - `eoi` clears the highest-priority set bit of the registered `isr`.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - `eoi` with `isr`==0 has no effect.
- A second INTA fall seen in REQ is not legal; it is treated as the first.
- `ir_req` changes during ACK1/ACK2 are ignored until IDLE.

## Timing
- Reset values:
  - State = IDLE, `int_out`=0, `cas_oe`=0, `cas_out`=0.
  - `data_oe`=0, `data_out`=0, `isr`=0, `inta_q`=1.
- `int_out` rises 2 clk after `ir_req` rises in IDLE: one clk to register the resolve, one to enter REQ.
- ISR set, `int_out` fall, and `cas_oe`/`cas_out` valid all occur 1 clk after the first INTA fall is seen.
- `data_oe` is high 1 clk after the second INTA fall and low 1 clk after its rise.
- Reset mid-sequence: all outputs go to reset values on the next edge, including bus drivers released. No partial ISR state survives.

## Configuration
- `PIC_AUTO_EOI_EN`
  - Defined: on the second INTA rise, the bit `isr[irq_id]` set by this sequence is cleared in the same clk as the return to IDLE. `eoi` stays functional.
  - Undefined: ISR bits clear only via `eoi`.

## Structure
- `pic_pkg` holds:
  - FSM state enum (IDLE, REQ, ACK1, ACK2).
  - `SPURIOUS_IR`=3'd7 and `NUM_IR`.
  - A vector-compose function.
- Sub-module `pic_prio_resolve` (combinational): inputs `ir_req` and `isr`; outputs `valid` and `id[2:0]`. It is used in IDLE, at the first INTA fall, and to pick the EOI target.

## Test plan
- Single mode, `vector_base`=5'h08, `ir_req`=8'h08 → `int_out` at +2 clk. On two INTA pulses: `isr`=8'h08, `data_out`=8'h43, `cas_oe`=0 throughout.
- Master cascade, `slave_map`=8'h04, `ir_req`=8'h04 → `cas_oe`=1, `cas_out`=3'd2 from first INTA until second rise. `data_oe` never 1. `isr`=8'h04.
- Slave, `slave_id`=3, `ir_req`=8'h01:
  - `cas_in`=3 → `isr`=8'h01 and vector driven.
  - `cas_in`=5 → no data, `isr`=0, back to IDLE.
- Nesting: with `isr`=8'h02, `ir_req`=8'h04 raises no INT. `ir_req`=8'h01 raises INT. `eoi` then clears bit 0 only. Request dropped before first INTA → `data_out`={base,3'd7}, `isr` unchanged.
- `rst_n`=0 during ACK2 → all outputs 0 next clk. With `PIC_AUTO_EOI_EN`, `isr` is back to 0 on the second INTA rise.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types, constants and helpers for the PIC interrupt-acknowledge sequencer.
package pic_pkg;

    localparam int unsigned NUM_IR = 8;
    localparam logic [2:0] SPURIOUS_IR = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StAck1,
        StAck2
    } state_e;

    function automatic logic [7:0] compose_vector(input logic [4:0] base, input logic [2:0] id);
        return {base, id};
    endfunction

endpackage

// File: rtl/pic_prio_resolve.sv
// Fixed-priority resolver: lowest-index request above the highest-priority in-service bit.
module pic_prio_resolve
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] ir_req,
    input  logic [NUM_IR-1:0] isr,
    output logic              valid,
    output logic [2:0]        id
);

    logic blocked;

    always_comb begin
        valid   = 1'b0;
        id      = '0;
        blocked = 1'b0;
        for (int unsigned i = 0; i < NUM_IR; i++) begin
            // An in-service bit masks its own level and everything below it.
            if (isr[i]) begin
                blocked = 1'b1;
            end
            if (!blocked && !valid && ir_req[i]) begin
                valid = 1'b1;
                id    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/pic_inta_sequencer.sv
// PIC INT/INTA sequencer: priority resolve, two-pulse INTA, cascade and vector drive, ISR/EOI.
// Define PIC_AUTO_EOI_EN to clear the serviced ISR bit automatically on the second INTA rise.
module pic_inta_sequencer
    import pic_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] ir_req,
    input  logic              sngl,
    input  logic              sp_en,
    input  logic [NUM_IR-1:0] slave_map,
    input  logic [2:0]        slave_id,
    input  logic [4:0]        vector_base,
    input  logic              inta_n,
    input  logic              eoi,
    input  logic [2:0]        cas_in,
    output logic              int_out,
    output logic [2:0]        cas_out,
    output logic              cas_oe,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic [NUM_IR-1:0] isr
);

    state_e            state_q, state_d;
    logic              inta_q, inta_d;
    logic              win_valid_q, win_valid_d;
    logic [2:0]        win_id_q, win_id_d;
    logic [2:0]        irq_id_q, irq_id_d;
    logic              spurious_q, spurious_d;
    logic              respond_q, respond_d;
    logic [NUM_IR-1:0] isr_q, isr_d;
    logic              sngl_q, sngl_d;
    logic              sp_en_q, sp_en_d;
    logic [NUM_IR-1:0] slave_map_q, slave_map_d;
    logic [2:0]        slave_id_q, slave_id_d;
    logic [4:0]        vec_base_q, vec_base_d;

    logic              req_valid, eoi_valid;
    logic [2:0]        req_id, eoi_id;
    logic [NUM_IR-1:0] set_mask, clr_mask;

    logic inta_fall, inta_rise;
    logic is_master, is_slave, slave_on_id, cas_match;

    assign inta_fall   = inta_q & ~inta_n;
    assign inta_rise   = ~inta_q & inta_n;
    assign is_master   = sngl_q | sp_en_q;
    assign is_slave    = ~sngl_q & ~sp_en_q;
    assign slave_on_id = ~sngl_q & sp_en_q & slave_map_q[irq_id_q];
    assign cas_match   = (cas_in == slave_id_q);

    pic_prio_resolve u_req_resolve (
        .ir_req (ir_req),
        .isr    (isr_q),
        .valid  (req_valid),
        .id     (req_id)
    );

    // Resolving the ISR against nothing yields its highest-priority set bit.
    pic_prio_resolve u_eoi_resolve (
        .ir_req (isr_q),
        .isr    ('0),
        .valid  (eoi_valid),
        .id     (eoi_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (win_valid_q) state_d = StReq;
            StReq:  if (inta_fall) state_d = StAck1;
            StAck1: if (inta_fall) state_d = (is_slave && !cas_match) ? StIdle : StAck2;
            StAck2: if (inta_rise) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        inta_d      = inta_n;
        win_valid_d = (state_q == StIdle) && req_valid;
        win_id_d    = req_id;
        irq_id_d    = irq_id_q;
        spurious_d  = spurious_q;
        respond_d   = respond_q;
        sngl_d      = sngl_q;
        sp_en_d     = sp_en_q;
        slave_map_d = slave_map_q;
        slave_id_d  = slave_id_q;
        vec_base_d  = vec_base_q;
        set_mask    = '0;
        clr_mask    = '0;

        if (state_q == StIdle && win_valid_q) begin
            irq_id_d    = win_id_q;
            spurious_d  = 1'b0;
            respond_d   = 1'b0;
            sngl_d      = sngl;
            sp_en_d     = sp_en;
            slave_map_d = slave_map;
            slave_id_d  = slave_id;
            vec_base_d  = vector_base;
        end

        if (state_q == StReq && inta_fall) begin
            irq_id_d   = req_valid ? req_id : SPURIOUS_IR;
            spurious_d = ~req_valid;
            if (is_master && req_valid) begin
                set_mask[req_id] = 1'b1;
            end
        end

        if (state_q == StAck1 && inta_fall) begin
            if (is_slave) begin
                respond_d = cas_match;
                if (cas_match && !spurious_q) begin
                    set_mask[irq_id_q] = 1'b1;
                end
            end else begin
                respond_d = ~slave_on_id;
            end
        end

`ifdef PIC_AUTO_EOI_EN
        // Reaching ACK2 non-spurious means this sequence set isr[irq_id].
        if (state_q == StAck2 && inta_rise && !spurious_q) begin
            clr_mask[irq_id_q] = 1'b1;
        end
`endif

        if (eoi && eoi_valid) begin
            clr_mask[eoi_id] = 1'b1;
        end

        isr_d = (isr_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inta_q      <= 1'b1;
            win_valid_q <= 1'b0;
            win_id_q    <= '0;
            irq_id_q    <= '0;
            spurious_q  <= 1'b0;
            respond_q   <= 1'b0;
            isr_q       <= '0;
            sngl_q      <= 1'b0;
            sp_en_q     <= 1'b0;
            slave_map_q <= '0;
            slave_id_q  <= '0;
            vec_base_q  <= '0;
        end else begin
            inta_q      <= inta_d;
            win_valid_q <= win_valid_d;
            win_id_q    <= win_id_d;
            irq_id_q    <= irq_id_d;
            spurious_q  <= spurious_d;
            respond_q   <= respond_d;
            isr_q       <= isr_d;
            sngl_q      <= sngl_d;
            sp_en_q     <= sp_en_d;
            slave_map_q <= slave_map_d;
            slave_id_q  <= slave_id_d;
            vec_base_q  <= vec_base_d;
        end
    end

    always_comb begin
        int_out  = (state_q == StReq);
        cas_oe   = ((state_q == StAck1) || (state_q == StAck2)) && slave_on_id;
        cas_out  = cas_oe ? irq_id_q : 3'd0;
        data_oe  = (state_q == StAck2) && respond_q;
        data_out = data_oe ? compose_vector(vec_base_q, irq_id_q) : 8'h00;
        isr      = isr_q;
    end

endmodule
